// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG scan bit unpacker.
// Contents: marker byte constants, the unpacker state enum and a helper that
// recognises restart (RSTn) marker codes.
package jpeg_pkg;

  localparam logic [7:0] MRK_PREFIX = 8'hFF;
  localparam logic [7:0] MRK_STUFF  = 8'h00;
  localparam logic [7:0] MRK_EOI    = 8'hD9;
  localparam logic [7:0] MRK_RST0   = 8'hD0;
  localparam logic [7:0] MRK_RST1   = 8'hD1;
  localparam logic [7:0] MRK_RST2   = 8'hD2;
  localparam logic [7:0] MRK_RST3   = 8'hD3;
  localparam logic [7:0] MRK_RST4   = 8'hD4;
  localparam logic [7:0] MRK_RST5   = 8'hD5;
  localparam logic [7:0] MRK_RST6   = 8'hD6;
  localparam logic [7:0] MRK_RST7   = 8'hD7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    GOT_FF = 2'd1,
    MARKER = 2'd2,
    DONE   = 2'd3
  } state_e;

  // True for RST0..RST7 marker codes.
  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code >= MRK_RST0) && (code <= MRK_RST7);
  endfunction

endpackage

// File: rtl/bit_fifo_shifter.sv
// Bit buffer for the scan unpacker: appends whole bytes at the tail and
// hands out 0..MAX_GET bits from the head, MSB-first.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush_i         discard every buffered bit
//   append_i        append append_byte_i at the tail this cycle
//   append_byte_i   byte to append (bit 7 enters first)
//   consume_i       drop len_i bits from the head this cycle
//   len_i           requested bit count, already clamped to MAX_GET
//   fill_o          number of valid bits held
//   enough_o        fill_o >= len_i
//   head_o          first len_i bits, right-aligned, zero when not enough
module bit_fifo_shifter
  import jpeg_pkg::*;
#(
  parameter int MAX_GET = 16,
  parameter int BUF_W   = 32,
  localparam int LW     = $clog2(MAX_GET + 1),
  localparam int CW     = $clog2(BUF_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               append_i,
  input  logic [7:0]         append_byte_i,
  input  logic               consume_i,
  input  logic [LW-1:0]      len_i,
  output logic [CW-1:0]      fill_o,
  output logic               enough_o,
  output logic [MAX_GET-1:0] head_o
);

  // Valid bits live right-aligned in buf_q[fill_q-1:0]; bit fill_q-1 is the
  // head. Bits above the fill level are stale and are masked on extraction.
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic [CW-1:0]      len_cw_s;
  logic [CW-1:0]      shamt_s;
  logic [CW-1:0]      fill_after_s;
  logic [MAX_GET-1:0] raw_s;
  logic [MAX_GET-1:0] mask_s;
  logic [MAX_GET-1:0] ones_s;

  assign len_cw_s = CW'(len_i);
  assign enough_o = (fill_q >= len_cw_s);
  assign shamt_s  = fill_q - len_cw_s;
  assign ones_s   = {MAX_GET{1'b1}};
  assign mask_s   = ones_s >> (LW'(MAX_GET) - len_i);
  assign raw_s    = MAX_GET'(buf_q >> shamt_s);
  assign fill_o   = fill_q;

  // Head extraction; nothing is presented until the request can be met.
  always_comb begin
    if (enough_o) begin
      head_o = raw_s & mask_s;
    end else begin
      head_o = {MAX_GET{1'b0}};
    end
  end

  // Next buffer contents: consume from the head first, then append at the tail,
  // so a simultaneous get always sees the pre-append bits.
  always_comb begin
    if (consume_i) begin
      fill_after_s = fill_q - len_cw_s;
    end else begin
      fill_after_s = fill_q;
    end
    buf_d  = buf_q;
    fill_d = fill_after_s;
    if (flush_i) begin
      buf_d  = {BUF_W{1'b0}};
      fill_d = {CW{1'b0}};
    end else if (append_i) begin
      buf_d  = {buf_q[BUF_W-9:0], append_byte_i};
      fill_d = fill_after_s + CW'(8);
    end else begin
      buf_d  = buf_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= {BUF_W{1'b0}};
      fill_q <= {CW{1'b0}};
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/scan_bit_unpacker.sv
// JPEG entropy-coded scan unpacker: removes 0xFF00 byte stuffing, skips 0xFF
// fill bytes, stops on markers until acknowledged and serves MSB-first bit
// fields to a consumer.
// Optional feature (macro JPEG_RST_MARKER_EN): acknowledging an RST0..RST7
// marker discards the remaining (padding) bits in the buffer.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_byte/in_ready scan byte input handshake
//   get_valid/get_len         bit request; get_len above MAX_GET acts as MAX_GET
//   get_ready/get_data        request satisfiable / requested bits (combinational)
//   marker_valid/marker_code  detected marker, held until marker_ack
//   marker_ack                consumer acknowledges the marker
//   bits_avail                current buffer fill
//   done                      EOI marker acknowledged
module scan_bit_unpacker
  import jpeg_pkg::*;
#(
  parameter int MAX_GET = 16,
  parameter int BUF_W   = 32,
  localparam int LW     = $clog2(MAX_GET + 1),
  localparam int CW     = $clog2(BUF_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  input  logic               get_valid,
  input  logic [LW-1:0]      get_len,
  output logic               get_ready,
  output logic [MAX_GET-1:0] get_data,
  output logic               marker_valid,
  output logic [7:0]         marker_code,
  input  logic               marker_ack,
  output logic [CW-1:0]      bits_avail,
  output logic               done
);

  state_e        state_q;
  logic          marker_valid_q;
  logic [7:0]    marker_code_q;
  logic          done_q;

  logic [LW-1:0] eff_len_s;
  logic [CW-1:0] fill_s;
  logic          accept_s;
  logic          consume_s;
  logic          append_s;
  logic [7:0]    append_byte_s;
  logic          flush_s;

  assign eff_len_s = (get_len > LW'(MAX_GET)) ? LW'(MAX_GET) : get_len;
  assign in_ready  = ((state_q == RUN) || (state_q == GOT_FF)) &&
                     (fill_s <= CW'(BUF_W - 8));
  assign accept_s  = in_valid && in_ready;
  assign consume_s = get_valid && get_ready;

  // Decide what an accepted byte contributes to the bit stream.
  always_comb begin
    append_s      = 1'b0;
    append_byte_s = in_byte;
    case (state_q)
      RUN: begin
        if (accept_s && (in_byte != MRK_PREFIX)) begin
          append_s = 1'b1;
        end else begin
          append_s = 1'b0;
        end
      end
      GOT_FF: begin
        // FF 00 is a stuffed data byte 0xFF.
        if (accept_s && (in_byte == MRK_STUFF)) begin
          append_s      = 1'b1;
          append_byte_s = MRK_PREFIX;
        end else begin
          append_s = 1'b0;
        end
      end
      default: begin
        append_s = 1'b0;
      end
    endcase
  end

  // Restart markers may drop the byte-alignment padding left in the buffer.
  always_comb begin
`ifdef JPEG_RST_MARKER_EN
    if ((state_q == MARKER) && marker_ack && is_rst_marker(marker_code_q)) begin
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
`else
    flush_s = 1'b0;
`endif
  end

  bit_fifo_shifter #(
    .MAX_GET(MAX_GET),
    .BUF_W  (BUF_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_s),
    .append_i     (append_s),
    .append_byte_i(append_byte_s),
    .consume_i    (consume_s),
    .len_i        (eff_len_s),
    .fill_o       (fill_s),
    .enough_o     (get_ready),
    .head_o       (get_data)
  );

  // Stuffing / marker state machine with registered marker and done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_s && (in_byte == MRK_PREFIX)) begin
            state_q <= GOT_FF;
          end else begin
            state_q <= RUN;
          end
        end
        GOT_FF: begin
          if (!accept_s) begin
            state_q <= GOT_FF;
          end else if (in_byte == MRK_STUFF) begin
            state_q <= RUN;
          end else if (in_byte == MRK_PREFIX) begin
            state_q <= GOT_FF;
          end else begin
            marker_code_q  <= in_byte;
            marker_valid_q <= 1'b1;
            state_q        <= MARKER;
          end
        end
        MARKER: begin
          if (marker_ack) begin
            marker_valid_q <= 1'b0;
            if (marker_code_q == MRK_EOI) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= MARKER;
          end
        end
        DONE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign marker_valid = marker_valid_q;
  assign marker_code  = marker_code_q;
  assign done         = done_q;
  assign bits_avail   = fill_s;

endmodule

// File: tb/tb_scan_bit_unpacker.sv
// Self-checking bench for scan_bit_unpacker: a bit-queue model of the scan
// stream is compared against the DUT every cycle, and directed sequences add
// hand-computed literal expectations.
module tb_scan_bit_unpacker;

  localparam int MG = 16;
  localparam int BW = 32;
  localparam int LW = $clog2(MG + 1);
  localparam int CW = $clog2(BW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          get_valid;
  logic [LW-1:0] get_len;
  logic          get_ready;
  logic [MG-1:0] get_data;
  logic          marker_valid;
  logic [7:0]    marker_code;
  logic          marker_ack;
  logic [CW-1:0] bits_avail;
  logic          done;

  always #5 clk = ~clk;

  scan_bit_unpacker #(.MAX_GET(MG), .BUF_W(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .get_valid(get_valid), .get_len(get_len),
    .get_ready(get_ready), .get_data(get_data),
    .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_ack(marker_ack), .bits_avail(bits_avail), .done(done)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       mq[$];       // decoded scan bits, head first
  bit       m_ff;        // last accepted byte was an unresolved 0xFF
  bit       m_mk;        // marker waiting for acknowledge
  bit       m_done;
  bit [7:0] m_code;

  function automatic void model_clear();
    mq.delete();
    m_ff = 1'b0; m_mk = 1'b0; m_done = 1'b0; m_code = 8'h00;
  endfunction

  function automatic void push_byte(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endfunction

  int       e_fill, e_n;
  bit       e_ir, e_gr;
  bit [31:0] e_data;

  function automatic void model_expect();
    e_fill = mq.size();
    e_ir   = !m_mk && !m_done && (e_fill <= BW - 8);
    e_n    = (int'(get_len) > MG) ? MG : int'(get_len);
    e_gr   = (e_fill >= e_n);
    e_data = 32'd0;
    if (e_gr) for (int i = 0; i < e_n; i++) e_data = {e_data[30:0], mq[i]};
  endfunction

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (rst) model_clear();
      model_expect();
      chk("in_ready",     {31'd0, in_ready},     {31'd0, e_ir});
      chk("bits_avail",   32'(bits_avail),       32'(e_fill));
      chk("get_ready",    {31'd0, get_ready},    {31'd0, e_gr});
      if (e_gr) chk("get_data", 32'(get_data), e_data);
      chk("marker_valid", {31'd0, marker_valid}, {31'd0, m_mk});
      chk("marker_code",  32'(marker_code),      32'(m_code));
      chk("done",         {31'd0, done},         {31'd0, m_done});
      @(posedge clk);
      if (rst) begin
        model_clear();
      end else begin
        model_expect();
        if (get_valid && e_gr) for (int i = 0; i < e_n; i++) void'(mq.pop_front());
        if (m_mk && marker_ack) begin
          m_mk = 1'b0;
          if (m_code == 8'hD9) m_done = 1'b1;
`ifdef JPEG_RST_MARKER_EN
          else if (m_code >= 8'hD0 && m_code <= 8'hD7) mq.delete();
`endif
        end
        if (in_valid && e_ir) begin
          if (!m_ff) begin
            if (in_byte == 8'hFF) m_ff = 1'b1;
            else push_byte(in_byte);
          end else if (in_byte == 8'h00) begin
            push_byte(8'hFF); m_ff = 1'b0;
          end else if (in_byte != 8'hFF) begin
            m_mk = 1'b1; m_code = in_byte; m_ff = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input bit iv, input bit [7:0] ib, input bit gv,
                     input int gl, input bit ack);
    in_valid = iv; in_byte = ib; get_valid = gv;
    get_len = LW'(gl); marker_ack = ack;
    #2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drv(1'b0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  task automatic send(input bit [7:0] b);
    drv(1'b1, b, 1'b0, 0, 1'b0); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_byte = 8'h00; get_valid = 1'b0;
    get_len = '0; marker_ack = 1'b0;
    tick(); tick();
    // reset state
    drv(1'b0, 8'h00, 1'b0, 8, 1'b0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_get_ready", {31'd0, get_ready}, 32'd0);
    chk("rst_get_data",  32'(get_data),      32'd0);
    chk("rst_bits",      32'(bits_avail),    32'd0);
    chk("rst_code",      32'(marker_code),   32'd0);
    drv(1'b0, 8'h00, 1'b0, 0, 1'b0);
    chk("rst_get_ready_len0", {31'd0, get_ready}, 32'd1);
    tick(); rst = 1'b0;

    // A5 3C -> 4,8,4 bit fields
    send(8'hA5); send(8'h3C);
    drv(1'b0, 8'h00, 1'b1, 4, 1'b0); chk("f037_a", 32'(get_data), 32'h000A); tick();
    drv(1'b0, 8'h00, 1'b1, 8, 1'b0); chk("f037_b", 32'(get_data), 32'h0053); tick();
    drv(1'b0, 8'h00, 1'b1, 4, 1'b0); chk("f037_c", 32'(get_data), 32'h000C); tick();
    idle(); chk("f037_bits", 32'(bits_avail), 32'd0);

    // stuffed FF 00
    do_reset();
    send(8'hFF); send(8'h00); send(8'h12);
    drv(1'b0, 8'h00, 1'b1, 16, 1'b0);
    chk("f038_data", 32'(get_data), 32'hFF12);
    chk("f038_mv", {31'd0, marker_valid}, 32'd0);
    tick(); idle();

    // fill bytes then EOI
    do_reset();
    send(8'h80); send(8'hFF); send(8'hFF); send(8'hD9);
    idle();
    chk("f039_mv",   {31'd0, marker_valid}, 32'd1);
    chk("f039_code", 32'(marker_code),      32'h00D9);
    drv(1'b0, 8'h00, 1'b1, 8, 1'b0); chk("f039_data", 32'(get_data), 32'h0080); tick();
    drv(1'b0, 8'h00, 1'b0, 0, 1'b1); tick();
    idle();
    chk("f039_done", {31'd0, done},         32'd1);
    chk("f039_ir",   {31'd0, in_ready},     32'd0);
    chk("f039_mv0",  {31'd0, marker_valid}, 32'd0);
    send(8'h12);
    idle(); chk("f039_bits", 32'(bits_avail), 32'd0);

    // RST marker with padding bits left behind
    do_reset();
    send(8'hF0); send(8'hFF);
    drv(1'b1, 8'hD3, 1'b1, 3, 1'b0); chk("f040_data", 32'(get_data), 32'h0007); tick();
    idle(); chk("f040_bits5", 32'(bits_avail), 32'd5);
    drv(1'b0, 8'h00, 1'b0, 0, 1'b1); tick();
    idle();
`ifdef JPEG_RST_MARKER_EN
    chk("f040_bits_ack", 32'(bits_avail), 32'd0);
`else
    chk("f040_bits_ack", 32'(bits_avail), 32'd5);
`endif
    chk("f040_ir", {31'd0, in_ready}, 32'd1);

    // fill limit, simultaneous get+append, oversize and zero get_len
    do_reset();
    send(8'h11); send(8'h22); send(8'h33);
    idle();
    chk("f041_bits24", 32'(bits_avail), 32'd24);
    chk("f041_ir24",   {31'd0, in_ready}, 32'd1);
    drv(1'b1, 8'h44, 1'b1, 8, 1'b0); chk("f041_sim_data", 32'(get_data), 32'h0011); tick();
    idle(); chk("f041_sim_bits", 32'(bits_avail), 32'd24);
    send(8'h55);
    idle();
    chk("f041_bits32", 32'(bits_avail), 32'd32);
    chk("f041_ir32",   {31'd0, in_ready}, 32'd0);
    drv(1'b1, 8'h66, 1'b1, 31, 1'b0); chk("f041_clamp", 32'(get_data), 32'h2233); tick();
    idle(); chk("f041_bits16", 32'(bits_avail), 32'd16);
    drv(1'b0, 8'h00, 1'b1, 0, 1'b0);
    chk("f041_len0_rdy",  {31'd0, get_ready}, 32'd1);
    chk("f041_len0_data", 32'(get_data),      32'd0);
    tick();
    drv(1'b0, 8'h00, 1'b1, 16, 1'b0); chk("f041_drain", 32'(get_data), 32'h4455); tick();
    idle();

    // reset while in GOT_FF
    do_reset();
    send(8'hFF);
    idle(); chk("f042_bits0", 32'(bits_avail), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h00);
    drv(1'b0, 8'h00, 1'b1, 8, 1'b0);
    chk("f042_bits8", 32'(bits_avail), 32'd8);
    chk("f042_data",  32'(get_data),   32'h0000);
    tick();
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
